// File: rtl/parallel_mul.sv
// parallel_mul: free-running sequential 1024x1024 -> 2048-bit unsigned multiplier.
// Runs a fixed 34-phase schedule:
//   phase 0      captures the operands and clears the accumulator,
//   phases 1..32 add one shifted 1024x32 partial product per cycle,
//   phase 33     publishes the finished product to Out in a single update.
module parallel_mul (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1023:0] In1,
  input  logic [1023:0] In2,
  output logic [2047:0] Out
);

  localparam logic [5:0] LAST_PHASE = 6'd33;

  logic [1023:0] a_reg;
  logic [1023:0] b_reg;
  logic [2047:0] acc;
  logic [5:0]    cnt;

  logic [4:0]    word_idx;
  logic [31:0]   b_word;
  logic [1055:0] partial;
  logic [2047:0] partial_shifted;

  // Select the multiplier word for this phase and form its partial product at its final bit position.
  always_comb begin
    // cnt 1..32 maps to word 0..31. The 5-bit subtraction wraps cnt=32 onto word 31.
    word_idx        = cnt[4:0] - 5'd1;
    b_word          = b_reg[{word_idx, 5'b00000} +: 32];
    partial         = {32'd0, a_reg} * {1024'd0, b_word};
    partial_shifted = {992'd0, partial} << {word_idx, 5'b00000};
  end

  // Phase counter, operand capture, accumulation and atomic publish.
  // A reset abandons any product that is in progress.
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      Out   <= '0;
    end else begin
      cnt <= (cnt == LAST_PHASE) ? 6'd0 : cnt + 6'd1;
      if (cnt == 6'd0) begin
        a_reg <= In1;
        b_reg <= In2;
        acc   <= '0;
      end else if (cnt != LAST_PHASE) begin
        acc <= acc + partial_shifted;
      end else begin
        Out <= acc;
      end
    end
  end

endmodule

// File: tb/tb_parallel_mul.sv
// tb_parallel_mul: self-checking bench for parallel_mul.
// The reference model is the plain 2048-bit product of the captured operands.
// Inputs are driven and Out is sampled on the falling edge.
module tb_parallel_mul;

  logic          clk;
  logic          rstn;
  logic [1023:0] In1;
  logic [1023:0] In2;
  logic [2047:0] Out;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string         name;
    logic [1023:0] a;
    logic [1023:0] b;
    logic [2047:0] expected;
  } vec_t;

  vec_t vecs[5];

  parallel_mul dut (
    .clk (clk),
    .rstn(rstn),
    .In1 (In1),
    .In2 (In2),
    .Out (Out)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the unsigned product of the two operands.
  function automatic logic [2047:0] refProduct(input logic [1023:0] a, input logic [1023:0] b);
    logic [2047:0] wa;
    logic [2047:0] wb;
    wa = {1024'd0, a};
    wb = {1024'd0, b};
    return wa * wb;
  endfunction

  function automatic logic [1023:0] randOperand();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Waits for one rising edge, then moves to the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [1023:0] a, input logic [1023:0] b);
    rstn = rst;
    In1  = a;
    In2  = b;
  endtask

  task automatic checkOutput(input string name, input logic [2047:0] expected);
    assertCount++;
    if (Out !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got lo=%h hi=%h, expected lo=%h hi=%h (%0d bits differ)",
               name, Out[127:0], Out[2047:1920], expected[127:0], expected[2047:1920],
               $countones(Out ^ expected));
    end
  endtask

  initial begin
    logic [1023:0] x;
    logic [1023:0] y;
    logic [1023:0] z;
    logic [2047:0] prevExp;
    logic [2047:0] curExp;

    vecs[0] = '{"basic_1x1", 1024'd1, 1024'd1, 2048'd1};
    vecs[1] = '{"cross_word_carry", 1024'hFFFFFFFF, 1024'hFFFFFFFF, 2048'hFFFFFFFE_00000001};
    vecs[2] = '{"word_placement_low", 1024'h1_00000001, 1024'd1, 2048'h1_00000001};
    vecs[3] = '{"word_placement_top", 1024'd1, 1024'd1 << 992, 2048'd1 << 992};
    vecs[4] = '{"full_width", {1024{1'b1}}, {1024{1'b1}},
                2048'd0 - (2048'd1 << 1025) + 2048'd1};

    // Reset held for three edges with arbitrary operands.
    applyStimulus(1'b1, randOperand(), randOperand());
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput($sformatf("reset_hold_%0d", i), '0);
      In1 = randOperand();
      In2 = randOperand();
    end

    // Directed vectors: zero until E+32, product at E+33, held through E+67.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, vecs[v].a, vecs[v].b);
      tick(1);
      rstn = 1'b0;
      tick(1);
      tick(32);
      checkOutput({vecs[v].name, "_before_publish"}, '0);
      tick(1);
      checkOutput({vecs[v].name, "_publish"}, vecs[v].expected);
      tick(33);
      checkOutput({vecs[v].name, "_held"}, vecs[v].expected);
      tick(1);
      checkOutput({vecs[v].name, "_republish"}, vecs[v].expected);
    end

    // Random back-to-back products, with operand noise outside the capture phase.
    applyStimulus(1'b1, '0, '0);
    tick(1);
    rstn    = 1'b0;
    prevExp = '0;
    for (int p = 0; p < 6; p++) begin
      x = randOperand();
      y = randOperand();
      if (p == 1) x = {992'd0, 32'(randOperand())};
      if (p == 2) y = '0;
      In1    = x;
      In2    = y;
      curExp = refProduct(x, y);
      tick(1);
      In1 = randOperand();
      In2 = randOperand();
      tick(32);
      checkOutput($sformatf("random_%0d_stale", p), prevExp);
      tick(1);
      checkOutput($sformatf("random_%0d_publish", p), curExp);
      prevExp = curExp;
    end

    // Operands change at E+5: the first product keeps the captured values.
    x = randOperand();
    y = randOperand();
    applyStimulus(1'b1, x, x);
    tick(1);
    rstn = 1'b0;
    tick(1);
    tick(4);
    In2 = y;
    tick(29);
    checkOutput("late_change_old", refProduct(x, x));
    tick(34);
    checkOutput("late_change_new", refProduct(x, y));

    // Reset asserted at capture+20 clears Out, and the full latency restarts.
    tick(20);
    rstn = 1'b1;
    tick(1);
    checkOutput("mid_reset_clear", '0);
    z = randOperand();
    applyStimulus(1'b0, x, z);
    tick(1);
    tick(32);
    checkOutput("mid_reset_restart_wait", '0);
    tick(1);
    checkOutput("mid_reset_restart_publish", refProduct(x, z));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/parallel_mul.md
# parallel_mul

Sequential unsigned 1024 × 1024-bit multiplier producing a 2048-bit product. It sits behind a register-mapped bus wrapper. The wrapper drives the two operands from 32 × 32-bit words each and copies the product into 64 × 32-bit readback words every clock. The block is free-running: it repeatedly samples the operands, multiplies them one 32-bit word of In2 per cycle, and publishes each finished product atomically.

## Interface
Parameters: none. All widths are fixed.

Ports:
- clk  in  1  Sole clock. All state changes on the rising edge.
- rstn  in  1  Reset. Synchronous and active-high despite the name: a 1 sampled at a rising edge resets the block.
- In1  in  1024  Multiplicand, unsigned. Bit 0 is the LSB; word i = In1[32i+31:32i].
- In2  in  1024  Multiplier, unsigned. Same word layout as In1.
- Out  out  2048  Last completed product In1×In2, unsigned, registered.

## Operation
- Internal registers:
  - A (1024): captured In1.
  - B (1024): captured In2.
  - acc (2048): accumulator.
  - cnt (6 bits, range 0..33): phase counter.
  - Out register (2048).
- The phase counter advances by 1 every non-reset edge, wrapping 33→0.
- Phase cnt=0 (CAPTURE): A←In1, B←In2, acc←0.
- Phases cnt=1..32 (ACCUMULATE, k=cnt−1):
  - acc ← acc + ((A × B[32k+31:32k]) << 32k).
  - The partial product A × word is a full 1056-bit result.
  - Addition is modulo 2^2048; overflow cannot occur for valid operands.
- Phase cnt=33 (PUBLISH): Out ← acc. Next edge returns to CAPTURE.
- In1/In2 are sampled only in CAPTURE. Changes at any other time have no effect on the product in progress.
- Out changes only in PUBLISH or on reset. It holds its value for the full 34-cycle period. There are no partially accumulated values on Out.
- There is no start/done handshake. Consumers sample Out whenever they like and accept up to one period of staleness.
- Reset (rstn=1 at an edge), including mid-computation: Out←0, acc←0, A←0, B←0, cnt←0. The computation in progress is abandoned.
- While rstn stays 1, all of these registers hold 0.
- Zero operands need no special case. The fixed schedule yields Out=0.

## Timing
- Reset value of Out: all zeros, visible after the first edge with rstn=1.
- Edges are numbered relative to E, the first edge with rstn=0 after reset:
  - E = capture.
  - E+1..E+32 = accumulate words 0..31.
  - E+33 = publish.
- Out reflects the operands present at edge E immediately after edge E+33. Latency is 33 edges from the capture edge.
- Throughput: one product per 34 cycles. Subsequent captures occur at E+34, E+68, …
- Critical path: one 1024×32 multiply plus one 2048-bit add per cycle. Pipelining is not permitted; the latency above is exact.

## Test plan
- Reset: hold rstn=1 for 3 edges with arbitrary operands -> Out=0 after the first edge and stays 0 throughout.
- Basic: In1=1, In2=1, release reset -> Out=0 until E+33, then Out=1 and held for 34 cycles.
- Cross-word carry: In1=0xFFFFFFFF, In2=0xFFFFFFFF -> Out=0xFFFFFFFE_00000001.
- Word placement: In1=2^32+1, In2=1 -> Out=2^32+1 (Out[31:0]=1, Out[63:32]=1, all other bits 0). Also In2=2^992 (top word) with In1=1 -> Out=2^992.
- Full width: In1=In2=2^1024−1 -> Out=2^2048−2^1025+1:
  - Out[0]=1.
  - Out[1024:1]=0.
  - Out[2047:1025]=all ones.
- Sampling/reset mid-operation:
  - Change operands at E+5 -> the E+33 result still reflects the E-captured values; the new operands appear at E+67.
  - Assert rstn at E+20 -> Out=0, and after release the full 33-edge latency restarts.
